// File: rtl/preprocess_mux_reader.sv
// preprocess_mux_reader
// Read-side engine for the preprocess buffer's 4-lane mux read port. It sweeps
// NUM_WORDS consecutive addresses from a latched base and delivers each word on
// a valid/ready stream. A credit-managed skid FIFO absorbs the fixed RAM latency.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   io_i_start              start pulse, honoured in IDLE only
//   io_i_abort              synchronous flush back to IDLE
//   io_i_base_addr          first address of the pass, latched on start
//   io_o_mux_rdaddr         read address to the buffer
//   io_i_mux_rddata         read data, RD_LATENCY cycles after the address
//   io_o_valid/io_i_ready   output stream handshake
//   io_o_data               stream word, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   io_o_last               marks word NUM_WORDS-1
//   io_o_busy               high outside IDLE
//   io_o_mux_done           one-cycle pulse at pass end
//
// Build option
//   PREPROC_MUX_RD_LANE_MASK_EN : when defined, bits [DATA_WIDTH-1:35] of every
//   output lane are forced to zero; otherwise lanes pass through unmodified.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start
// S_READ  | issuing addresses, bounded by FIFO credits
// S_DRAIN | all addresses issued, waiting for the last word to be taken
// S_DONE  | one-cycle mux_done pulse, then back to IDLE

module preprocess_mux_reader #(
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_WORDS  = 1024,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    io_i_start,
    input  logic                    io_i_abort,
    input  logic [ADDR_WIDTH-1:0]   io_i_base_addr,
    output logic [ADDR_WIDTH-1:0]   io_o_mux_rdaddr,
    input  logic [4*DATA_WIDTH-1:0] io_i_mux_rddata,
    output logic                    io_o_valid,
    input  logic                    io_i_ready,
    output logic [4*DATA_WIDTH-1:0] io_o_data,
    output logic                    io_o_last,
    output logic                    io_o_busy,
    output logic                    io_o_mux_done
);

    localparam int WORD_W  = 4 * DATA_WIDTH;
    localparam int CNT_W   = $clog2(NUM_WORDS + 1);
    localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int FCNT1_W = FCNT_W + 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0]   WORDS_C    = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0]   LAST_IDX_C = CNT_W'(NUM_WORDS - 1);
    localparam logic [FCNT_W:0]    DEPTH_C    = FCNT1_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_MAX_C  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [RD_LATENCY-1:0]   pipe_q, pipe_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [WORD_W-1:0]       fifo_mem_q [FIFO_DEPTH];

    logic [FCNT_W-1:0]       inflight;
    logic [FCNT_W:0]         credit_used;
    logic                    fifo_valid;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic                    head_last;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic [WORD_W-1:0]       head_word;

    // Credits: a read may only be issued if the FIFO can hold it together with
    // every read still travelling through the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + FCNT_W'(pipe_q[i]);
        end
        credit_used = {1'b0, fifo_cnt_q} + {1'b0, inflight};
        fifo_valid  = (fifo_cnt_q != '0);
        pop         = fifo_valid & io_i_ready;
        push        = pipe_q[RD_LATENCY-1];
        head_last   = (acc_cnt_q == LAST_IDX_C);
        issue       = (state_q == S_READ) && (issue_cnt_q < WORDS_C) && (credit_used < DEPTH_C);
        issue_addr  = base_q + ADDR_WIDTH'(issue_cnt_q);
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        acc_cnt_d   = acc_cnt_q;
        last_addr_d = last_addr_q;
        pipe_d      = (pipe_q << 1) | RD_LATENCY'(issue);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;

        if (issue) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
            last_addr_d = issue_addr;
        end
        if (pop) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
            rd_ptr_d  = (rd_ptr_q == PTR_MAX_C) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX_C) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (io_i_start) begin
                    state_d     = S_READ;
                    base_d      = io_i_base_addr;
                    issue_cnt_d = '0;
                    acc_cnt_d   = '0;
                end
            end
            S_READ: begin
                if (issue_cnt_d == WORDS_C) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle;
        // reads still in the pipe are dropped by clearing their valid bits.
        if (io_i_abort) begin
            state_d     = S_IDLE;
            issue_cnt_d = '0;
            acc_cnt_d   = '0;
            pipe_d      = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            fifo_cnt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            acc_cnt_q   <= '0;
            last_addr_q <= '0;
            pipe_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
            last_addr_q <= last_addr_d;
            pipe_q      <= pipe_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: the head is only exposed while the count says valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= io_i_mux_rddata;
        end
    end

    always_comb begin
        head_word = fifo_mem_q[rd_ptr_q];
`ifdef PREPROC_MUX_RD_LANE_MASK_EN
        for (int k = 0; k < 4; k++) begin
            for (int b = 35; b < DATA_WIDTH; b++) begin
                head_word[k*DATA_WIDTH + b] = 1'b0;
            end
        end
`endif
    end

    // The address is presented in the issue cycle itself so the credit check
    // only has to cover RD_LATENCY reads; between issues it holds its last value.
    assign io_o_mux_rdaddr = issue ? issue_addr : last_addr_q;
    assign io_o_valid      = fifo_valid;
    assign io_o_data       = fifo_valid ? head_word : '0;
    assign io_o_last       = fifo_valid & head_last;
    assign io_o_busy       = (state_q != S_IDLE);
    assign io_o_mux_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_preprocess_mux_reader.sv
module tb_preprocess_mux_reader;

    localparam int DW = 39;
    localparam int AW = 12;
    localparam int WW = 4 * DW;
    localparam int N0 = 8;
    localparam int L0 = 3;
    localparam int D0 = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // main instance
    logic          start, abort_s, ready, valid, last, busy, done;
    logic [AW-1:0] base, addr;
    logic [WW-1:0] rddata, data;
    // single-word instance
    logic          start1, abort1, ready1, valid1, last1, busy1, done1;
    logic [AW-1:0] base1, addr1;
    logic [WW-1:0] rddata1, data1;

    bit ram_ones = 1'b0;
    int errors = 0;
    int checks = 0;

    preprocess_mux_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(N0),
                            .RD_LATENCY(L0), .FIFO_DEPTH(D0)) u_dut (
        .clock(clock), .reset_n(reset_n), .io_i_start(start), .io_i_abort(abort_s),
        .io_i_base_addr(base), .io_o_mux_rdaddr(addr), .io_i_mux_rddata(rddata),
        .io_o_valid(valid), .io_i_ready(ready), .io_o_data(data), .io_o_last(last),
        .io_o_busy(busy), .io_o_mux_done(done));

    preprocess_mux_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(1),
                            .RD_LATENCY(1), .FIFO_DEPTH(3)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .io_i_start(start1), .io_i_abort(abort1),
        .io_i_base_addr(base1), .io_o_mux_rdaddr(addr1), .io_i_mux_rddata(rddata1),
        .io_o_valid(valid1), .io_i_ready(ready1), .io_o_data(data1), .io_o_last(last1),
        .io_o_busy(busy1), .io_o_mux_done(done1));

    // Buffer content: a fixed function of the address, distinct per lane.
    function automatic logic [WW-1:0] ram_word(input logic [AW-1:0] a);
        logic [WW-1:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k*DW +: DW] = {a, 2'(k), 25'((32'(a) * 32'd40503) ^ (32'(k) * 32'h5A5A5))};
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] exp_word(input logic [AW-1:0] a, input bit ones);
        logic [WW-1:0] w;
        w = ones ? {WW{1'b1}} : ram_word(a);
`ifdef PREPROC_MUX_RD_LANE_MASK_EN
        for (int k = 0; k < 4; k++) begin
            for (int b = 35; b < DW; b++) w[k*DW + b] = 1'b0;
        end
`endif
        return w;
    endfunction

    // RAM models: address seen at a clock edge, data available L cycles after
    // the cycle in which the address was presented.
    logic [AW-1:0] a_h0, a_h1, a_h2, a1_h0;
    always @(posedge clock) begin
        a_h0  <= addr;
        a_h1  <= a_h0;
        a_h2  <= a_h1;
        a1_h0 <= addr1;
    end
    always_comb rddata  = ram_ones ? {WW{1'b1}} : ram_word(a_h2);
    always_comb rddata1 = ram_ones ? {WW{1'b1}} : ram_word(a1_h0);

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] base;
        int rmode;      // 0 always ready, 1 toggle, 2 random, 3 mostly stalled
        int restart;    // pulse start again mid-pass
        int ones;       // buffer returns all-ones
        int exp_words;
        int exp_dones;
    } vec_t;

    function automatic logic pick_ready(input int rmode, input int cyc);
        case (rmode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return $urandom_range(0, 3) == 0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic run_pass(input vec_t v);
        int got, dones, cyc, first_valid;
        bit stall, done_seen, ended;
        logic [WW-1:0] pdata;
        logic plast;
        got = 0; dones = 0; cyc = 0; first_valid = -1;
        stall = 0; done_seen = 0; ended = 0; pdata = '0; plast = 0;
        ram_ones = (v.ones != 0);
        base  = v.base;
        start = 1'b1;
        ready = 1'b0;
        @(negedge clock);
        cyc = 1;
        start = 1'b0;
        base  = AW'($urandom);
        while (cyc < 400 && !ended) begin
            if (done_seen) begin
                chk("busy_after_done", busy, 1'b0);
                ended = 1;
            end else begin
                if (stall) begin
                    chk("hold_valid", valid, 1'b1);
                    chk("hold_data", data, pdata);
                    chk("hold_last", last, plast);
                end
                if (valid && first_valid < 0) first_valid = cyc;
                if (done) begin
                    dones++;
                    done_seen = 1;
                    chk("busy_at_done", busy, 1'b1);
                end
                ready = pick_ready(v.rmode, cyc);
                if (v.restart != 0 && cyc == 4) start = 1'b1;
                else start = 1'b0;
                if (valid && ready) begin
                    chk("word_data", data, exp_word(AW'(v.base + AW'(got)), v.ones != 0));
                    chk("word_last", last, got == v.exp_words - 1);
                    got++;
                end
                stall = valid && !ready;
                pdata = data;
                plast = last;
                @(negedge clock);
                cyc++;
            end
        end
        start = 1'b0;
        ready = 1'b0;
        chk("pass_ended", ended, 1'b1);
        chk("word_count", got, v.exp_words);
        chk("done_count", dones, v.exp_dones);
        chk("first_valid_latency", first_valid >= 1 + L0, 1'b1);
        ram_ones = 1'b0;
    endtask

    vec_t vecs[7];
    vec_t v;
    int dcnt, vcnt, got1, dones1;

    initial begin
        vecs[0] = '{12'h000, 0, 0, 0, N0, 1};
        vecs[1] = '{12'hFFE, 0, 0, 0, N0, 1};
        vecs[2] = '{12'h123, 1, 0, 0, N0, 1};
        vecs[3] = '{12'h7F0, 2, 0, 0, N0, 1};
        vecs[4] = '{12'h050, 0, 1, 0, N0, 1};
        vecs[5] = '{12'hABC, 3, 0, 0, N0, 1};
        vecs[6] = '{12'hF00, 2, 0, 1, N0, 1};

        start = 0; abort_s = 0; ready = 0; base = '0;
        start1 = 0; abort1 = 0; ready1 = 0; base1 = '0;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_valid", valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_last", last, 1'b0);
        chk("rst_addr", addr, '0);
        chk("rst_data", data, '0);
        chk("rst_last_n1", last1, 1'b0);
        chk("rst_valid_n1", valid1, 1'b0);
        reset_n = 1'b1;
        @(negedge clock);

        // start and abort together in IDLE: abort wins
        start = 1; abort_s = 1; base = 12'h055;
        @(negedge clock);
        start = 0; abort_s = 0;
        chk("start_abort_busy", busy, 1'b0);
        @(negedge clock);
        chk("start_abort_busy2", busy, 1'b0);
        chk("start_abort_valid", valid, 1'b0);

        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            run_pass(v);
            repeat (2) @(negedge clock);
        end

        // abort mid-pass with downstream stalled
        base = 12'h3C0; start = 1; ready = 0;
        @(negedge clock);
        start = 0;
        repeat (6) @(negedge clock);
        chk("pre_abort_busy", busy, 1'b1);
        abort_s = 1;
        @(negedge clock);
        abort_s = 0;
        chk("abort_valid", valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        ready = 1;
        dcnt = 0; vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done) dcnt++;
            if (valid) vcnt++;
        end
        ready = 0;
        chk("abort_no_done", dcnt, 0);
        chk("abort_no_valid", vcnt, 0);
        v = '{12'h100, 0, 0, 0, N0, 1};
        run_pass(v);
        repeat (2) @(negedge clock);

        // asynchronous reset in the middle of a pass
        base = 12'h200; start = 1; ready = 1;
        @(negedge clock);
        start = 0;
        repeat (6) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_addr", addr, '0);
        @(negedge clock);
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (done || valid) dcnt++;
        end
        ready = 0;
        chk("arst_quiet", dcnt, 0);
        v = '{12'hFFC, 1, 0, 0, N0, 1};
        run_pass(v);

        // single-word pass
        base1 = 12'hFFF; start1 = 1; ready1 = 1;
        @(negedge clock);
        start1 = 0;
        got1 = 0; dones1 = 0;
        for (int c = 0; c < 20; c++) begin
            if (done1) dones1++;
            if (valid1 && ready1) begin
                chk("n1_data", data1, exp_word(12'hFFF, 1'b0));
                chk("n1_last", last1, 1'b1);
                got1++;
            end
            @(negedge clock);
        end
        chk("n1_words", got1, 1);
        chk("n1_dones", dones1, 1);
        chk("n1_busy_end", busy1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
